addsub16_result_stage: RTL and testbench

- Registered output stage directly downstream of the 16-bit prefix add/sub unit `addsub16`.
- Captures the unit's sum `S` together with the operands that produced it, then derives status flags N, Z, C and V.
- Presents the result on a valid/ready interface. A 2-entry skid buffer gives full throughput under backpressure.
- Keeps a count of accepted results for performance and debug readout.

---
 rtl/addsub_pkg.sv | 48 ++++
 rtl/addsub16_result_stage_if.sv | 34 +++
 rtl/addsub_skid2.sv | 88 ++++++++
 rtl/addsub16_result_stage.sv | 60 ++++++
 tb/tb_addsub16_result_stage.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pkg
// Purpose  : Shared types, flag indices and flag derivation for addsub16.
// Revision : 1.0
// ============================================================================
package addsub_pkg;

  localparam int DEF_WIDTH = 16;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] s;
    logic [3:0]           flags;
  } result_t;

  // C is carry-out for add and borrow for subtract.
  function automatic logic [3:0] addsub_flags(
    input logic [DEF_WIDTH-1:0] a,
    input logic [DEF_WIDTH-1:0] b,
    input logic                 sub,
    input logic [DEF_WIDTH-1:0] s
  );
    logic [3:0] f;
    logic       am, bm, sm;
    f  = '0;
    am = a[DEF_WIDTH-1];
    bm = b[DEF_WIDTH-1];
    sm = s[DEF_WIDTH-1];
    f[FLAG_N] = sm;
    f[FLAG_Z] = (s == '0);
    f[FLAG_C] = sub ? (a < b) : (s < a);
    f[FLAG_V] = sub ? ((am != bm) && (sm != am)) : ((am == bm) && (sm != am));
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub16_result_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : addsub16_result_stage_if
// Purpose  : Upstream/downstream handshake and counter bundle of the stage.
// Revision : 1.0
// ============================================================================
interface addsub16_result_stage_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic [WIDTH-1:0] in_s;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic [3:0]       out_flags;
  logic             clr_cnt;
  logic [CNT_W-1:0] acc_cnt;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_s, out_ready, clr_cnt,
    input  in_ready, out_valid, out_s, out_flags, acc_cnt
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_s, out_ready, clr_cnt,
    output in_ready, out_valid, out_s, out_flags, acc_cnt
  );
endinterface
`default_nettype wire

// File: rtl/addsub_skid2.sv
`default_nettype none
// ============================================================================
// Module   : addsub_skid2
// Purpose  : Generic 2-entry valid/ready skid buffer with registered ready.
// Revision : 1.0
// ============================================================================
module addsub_skid2
  import addsub_pkg::*;
#(
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] out_q, skid_q;
  logic              ready_q;
  logic              accept, pop;
  logic              load_out, load_skid, out_from_skid;

  assign accept    = in_valid & ready_q;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state_q != SKID_EMPTY);
  assign in_ready  = ready_q;
  assign out_data  = out_q;

  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          load_out = 1'b1;
          state_d  = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && pop) begin
          load_out = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = SKID_TWO;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (pop) begin
          out_from_skid = 1'b1;
          state_d       = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // Ready is registered from the next state so out_ready never reaches in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      ready_q <= 1'b1;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != SKID_TWO);
      if (load_out) begin
        out_q <= in_data;
      end else if (out_from_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/addsub16_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : addsub16_result_stage
// Purpose  : Registers addsub16 results with N/Z/C/V flags behind a skid buffer.
// Revision : 1.0
// ============================================================================
module addsub16_result_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  addsub16_result_stage_if.slave   bus
);

  localparam int REC_W = WIDTH + 4;

  result_t          in_rec;
  result_t          out_rec;
  logic             accept;
  logic [CNT_W-1:0] cnt_q;

  assign in_rec.s     = bus.in_s;
  assign in_rec.flags = addsub_flags(bus.in_a, bus.in_b, bus.in_sub, bus.in_s);

  addsub_skid2 #(
    .DATA_W (REC_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_rec),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_rec)
  );

  assign bus.out_s     = out_rec.s;
  assign bus.out_flags = out_rec.flags;

  assign accept = bus.in_valid & bus.in_ready;

  // Clear wins over a coincident accept; that accept is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.clr_cnt) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.acc_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub16_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub16_result_stage
// Purpose  : Directed self-checking bench for addsub16_result_stage.
// Revision : 1.0
// ============================================================================
module tb_addsub16_result_stage;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic [3:0]  f;
  } vec_t;

  logic clk;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  vec_t vecs [6];

  addsub16_result_stage_if #(.WIDTH(16), .CNT_W(16)) bus ();

  addsub16_result_stage #(.WIDTH(16), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic [15:0] s);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    bus.in_s     = s;
  endtask

  initial begin
    // {N,Z,C,V} worked out by hand for each vector
    vecs[0] = '{16'hffff, 16'h0001, 1'b0, 16'h0000, 4'b0110};
    vecs[1] = '{16'h55aa, 16'haa55, 1'b0, 16'hffff, 4'b1000};
    vecs[2] = '{16'h0000, 16'h0001, 1'b1, 16'hffff, 4'b1010};
    vecs[3] = '{16'h0069, 16'h0069, 1'b1, 16'h0000, 4'b0100};
    vecs[4] = '{16'h7fff, 16'h0001, 1'b0, 16'h8000, 4'b1001};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7fff, 4'b0001};

    clk           = 1'b0;
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr_cnt   = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);

    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_s",     32'(bus.out_s),     32'd0);
    check("rst_out_flags", 32'(bus.out_flags), 32'd0);
    check("rst_acc_cnt",   32'(bus.acc_cnt),   32'd0);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;

    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].s);
      @(negedge clk);
      check($sformatf("flag_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("flag_s_%0d", i),     32'(bus.out_s),     32'(vecs[i].s));
      check($sformatf("flag_f_%0d", i),     32'(bus.out_flags), 32'(vecs[i].f));
      check($sformatf("flag_rdy_%0d", i),   32'(bus.in_ready),  32'd1);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'hxxxx);
    @(negedge clk);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("idle_out_s",     32'(bus.out_s),     32'h7fff);
    check("idle_out_flags", 32'(bus.out_flags), 32'h1);
    check("idle_acc_cnt",   32'(bus.acc_cnt),   32'd6);

    bus.clr_cnt = 1'b1;
    @(negedge clk);
    check("clr_idle", 32'(bus.acc_cnt), 32'd0);
    bus.clr_cnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'(i), 16'h0001, 1'b0, 16'(i + 1));
      @(negedge clk);
      check($sformatf("stream_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("stream_s_%0d", i),     32'(bus.out_s),     32'(i + 1));
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    check("stream_cnt",   32'(bus.acc_cnt),   32'd5);
    check("stream_drain", 32'(bus.out_valid), 32'd0);

    // Backpressure: three offers, only two fit
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0010, 16'h0001, 1'b0, 16'h0011);
    @(negedge clk);
    check("bp_rdy_1", 32'(bus.in_ready), 32'd1);
    check("bp_s_1",   32'(bus.out_s),    32'h0011);
    drive(1'b1, 16'h0020, 16'h0001, 1'b0, 16'h0021);
    @(negedge clk);
    check("bp_rdy_2", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 16'h0030, 16'h0001, 1'b0, 16'h0031);
    @(negedge clk);
    check("bp_rdy_3",  32'(bus.in_ready),  32'd0);
    check("bp_hold_s", 32'(bus.out_s),     32'h0011);
    check("bp_hold_v", 32'(bus.out_valid), 32'd1);
    check("bp_cnt_2",  32'(bus.acc_cnt),   32'd7);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_s2",  32'(bus.out_s),    32'h0021);
    check("bp_rdy_up",  32'(bus.in_ready), 32'd1);
    check("bp_cnt_pop", 32'(bus.acc_cnt),  32'd7);
    @(negedge clk);
    check("bp_pop_s3", 32'(bus.out_s),     32'h0031);
    check("bp_v3",     32'(bus.out_valid), 32'd1);
    check("bp_cnt_3",  32'(bus.acc_cnt),   32'd8);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    check("bp_empty", 32'(bus.out_valid), 32'd0);

    bus.clr_cnt = 1'b1;
    drive(1'b1, 16'h0100, 16'h0001, 1'b0, 16'h0101);
    @(negedge clk);
    check("clr_acc_cnt", 32'(bus.acc_cnt),   32'd0);
    check("clr_acc_s",   32'(bus.out_s),     32'h0101);
    check("clr_acc_v",   32'(bus.out_valid), 32'd1);
    bus.clr_cnt = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    check("clr_after", 32'(bus.acc_cnt), 32'd0);

    drive(1'b1, 16'h0001, 16'h0001, 1'b0, 16'h0002);
    repeat (65535) @(posedge clk);
    @(negedge clk);
    check("wrap_full", 32'(bus.acc_cnt), 32'hffff);
    @(negedge clk);
    check("wrap_zero", 32'(bus.acc_cnt), 32'd0);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);

    // Fill both entries, then reset between edges
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h1000, 16'h0111, 1'b0, 16'h1111);
    @(negedge clk);
    drive(1'b1, 16'h2000, 16'h0222, 1'b0, 16'h2222);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    check("pre_rst_rdy", 32'(bus.in_ready),  32'd0);
    check("pre_rst_v",   32'(bus.out_valid), 32'd1);
    check("pre_rst_cnt", 32'(bus.acc_cnt),   32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_v",   32'(bus.out_valid), 32'd0);
    check("async_rst_rdy", 32'(bus.in_ready),  32'd1);
    check("async_rst_cnt", 32'(bus.acc_cnt),   32'd0);
    check("async_rst_s",   32'(bus.out_s),     32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_v_%0d", i), 32'(bus.out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
